// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_pkg
// Description : Shared definitions for the matrix multiply engine.
//               - FSM state encoding (IDLE, MAC, EMIT, DONE)
//               - operand select encodings for the load port
//               - narrowing function: accumulator -> result width, either
//                 two's-complement wrap or saturating clamp
// Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      EMIT = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   // Working width of the narrowing function. Callers sign-extend their
   // accumulator into it and keep the low bits of the result; any result
   // width strictly below this value is supported.
   localparam int NARROW_W = 128;

   // Reduces a sign-extended value to out_w bits and returns it sign-extended
   // again. When the value already fits, both modes return it unchanged.
   function automatic logic signed [NARROW_W-1:0] narrow_acc(
      input logic signed [NARROW_W-1:0] val,
      input int                         out_w,
      input logic                       sat
   );
      logic signed [NARROW_W-1:0] hi;
      logic signed [NARROW_W-1:0] lo;
      logic signed [NARROW_W-1:0] r;
      hi = (NARROW_W'(1) <<< (out_w - 1)) - NARROW_W'(1);
      lo = ~hi;
      if (sat) begin
         if (val > hi)      r = hi;
         else if (val < lo) r = lo;
         else               r = val;
      end else begin
         // Shift the kept bits to the top and back down arithmetically:
         // this discards the upper bits and re-extends the new sign bit.
         r = (val <<< (NARROW_W - out_w)) >>> (NARROW_W - out_w);
      end
      return r;
   endfunction

endpackage : mac_pkg
`default_nettype wire

// File: rtl/mac_matmul_engine_mac_unit.sv
`default_nettype none
// ============================================================================
// Module      : mac_unit
// Description : Registered signed multiply-accumulate with clear.
//               The accumulator register updates when i_en is high with
//               (i_clr ? 0 : acc) + i_a*i_b, the full-precision product being
//               sign-extended to ACC_W. o_sum presents the value being written
//               this cycle so the caller can capture a finished sum on the
//               same edge the accumulator takes it.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_en            - accumulate this cycle
//               i_clr           - start a new sum (ignore held accumulator)
//               i_a, i_b        - signed DATA_W operands
//               o_sum           - signed ACC_W accumulator next value
// Revision    : 1.0 - initial release
// ============================================================================
module mac_unit #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 36
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_en,
   input  logic                     i_clr,
   input  logic signed [DATA_W-1:0] i_a,
   input  logic signed [DATA_W-1:0] i_b,
   output logic signed [ACC_W-1:0]  o_sum
);

   logic signed [2*DATA_W-1:0] w_prod;
   logic signed [ACC_W-1:0]    w_base;
   logic signed [ACC_W-1:0]    acc_q;
   logic signed [ACC_W-1:0]    acc_d;

   always_comb begin
      w_prod = i_a * i_b;
      w_base = i_clr ? '0 : acc_q;
      o_sum  = w_base + ACC_W'(w_prod);
      acc_d  = i_en ? o_sum : acc_q;
   end

   always_ff @(posedge clk) begin
      if (rst) acc_q <= '0;
      else     acc_q <= acc_d;
   end

endmodule : mac_unit
`default_nettype wire

// File: rtl/mac_matmul_engine.sv
`default_nettype none
// ============================================================================
// Module      : mac_matmul_engine
// Description : NxN signed matrix multiplier C = A*B using one sequential
//               multiply-accumulate datapath. Operands are written through a
//               load port into internal register arrays; results stream out in
//               row-major order over valid/ready.
//               Build option MAC_SAT_EN: saturate results that do not fit in
//               OUT_W bits instead of wrapping them.
// Ports       : clk, rst                    - clock, sync active-high reset
//               ld_valid/ld_sel/ld_row/ld_col/ld_data - operand write port
//               ld_err                      - pulse: last write rejected
//               start                       - begin multiplication (IDLE only)
//               busy                        - computation in progress
//               res_valid/res_ready/res_data/res_last - result stream
//               done                        - pulse after final result taken
// Revision    : 1.0 - initial release
// ============================================================================
module mac_matmul_engine
   import mac_pkg::*;
#(
   parameter int N      = 10,
   parameter int DATA_W = 16,
   parameter int OUT_W  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ld_valid,
   input  logic                     ld_sel,
   input  logic [$clog2(N)-1:0]     ld_row,
   input  logic [$clog2(N)-1:0]     ld_col,
   input  logic signed [DATA_W-1:0] ld_data,
   output logic                     ld_err,
   input  logic                     start,
   output logic                     busy,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic signed [OUT_W-1:0]  res_data,
   output logic                     res_last,
   output logic                     done
);

   localparam int ACC_W = 2*DATA_W + $clog2(N);
   localparam int IDX_W = $clog2(N);
   localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(N - 1);

`ifdef MAC_SAT_EN
   localparam logic c_sat = 1'b1;
`else
   localparam logic c_sat = 1'b0;
`endif

   state_t                   state_q, state_d;
   logic [IDX_W-1:0]         i_q, i_d;
   logic [IDX_W-1:0]         j_q, j_d;
   logic [IDX_W-1:0]         k_q, k_d;
   logic signed [OUT_W-1:0]  res_data_q, res_data_d;
   logic                     ld_err_q, ld_err_d;

   // Operand storage; deliberately not reset so loaded matrices survive rst.
   logic signed [DATA_W-1:0] mem_a_q [N][N];
   logic signed [DATA_W-1:0] mem_b_q [N][N];

   logic                     w_idx_ok;
   logic                     w_wr;
   logic                     w_mac_en;
   logic signed [DATA_W-1:0] w_a;
   logic signed [DATA_W-1:0] w_b;
   logic signed [ACC_W-1:0]  w_sum;
   logic signed [NARROW_W-1:0] w_narrow;
   logic signed [OUT_W-1:0]  w_res_next;
   logic                     w_unused_narrow_hi;

   // ---------------------------------------------------------------- load port
   always_comb begin
      w_idx_ok = (32'(ld_row) < 32'(N)) && (32'(ld_col) < 32'(N));
      w_wr     = ld_valid && !rst && (state_q == IDLE) && w_idx_ok;
      ld_err_d = ld_valid && !((state_q == IDLE) && w_idx_ok);
   end

   always_ff @(posedge clk) begin
      if (w_wr) begin
         if (ld_sel == SEL_A) mem_a_q[ld_row][ld_col] <= ld_data;
         else                 mem_b_q[ld_row][ld_col] <= ld_data;
      end
   end

   // ----------------------------------------------------------------- datapath
   always_comb begin
      w_a = mem_a_q[i_q][k_q];
      w_b = mem_b_q[k_q][j_q];
   end

   mac_unit #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_mac_unit (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_mac_en),
      .i_clr  (k_q == '0),
      .i_a    (w_a),
      .i_b    (w_b),
      .o_sum  (w_sum)
   );

   always_comb begin
      w_narrow           = narrow_acc(NARROW_W'(w_sum), OUT_W, c_sat);
      w_res_next         = w_narrow[OUT_W-1:0];
      w_unused_narrow_hi = ^w_narrow[NARROW_W-1:OUT_W];
   end

   // ---------------------------------------------------------------------- FSM
   always_comb begin
      state_d    = state_q;
      i_d        = i_q;
      j_d        = j_q;
      k_d        = k_q;
      res_data_d = res_data_q;
      w_mac_en   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = MAC;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
            end
         end
         MAC: begin
            w_mac_en = 1'b1;
            if (k_q == c_idx_last) begin
               // The last product lands in the accumulator on this edge, so
               // the result register takes the same next value.
               k_d        = '0;
               res_data_d = w_res_next;
               state_d    = EMIT;
            end else begin
               k_d = k_q + IDX_W'(1);
            end
         end
         EMIT: begin
            if (res_ready) begin
               if ((i_q == c_idx_last) && (j_q == c_idx_last)) begin
                  state_d = DONE;
                  i_d     = '0;
                  j_d     = '0;
               end else begin
                  state_d = MAC;
                  if (j_q == c_idx_last) begin
                     j_d = '0;
                     i_d = i_q + IDX_W'(1);
                  end else begin
                     j_d = j_q + IDX_W'(1);
                  end
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         i_q        <= '0;
         j_q        <= '0;
         k_q        <= '0;
         res_data_q <= '0;
         ld_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         i_q        <= i_d;
         j_q        <= j_d;
         k_q        <= k_d;
         res_data_q <= res_data_d;
         ld_err_q   <= ld_err_d;
      end
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      busy      = (state_q != IDLE);
      res_valid = (state_q == EMIT);
      res_last  = (state_q == EMIT) && (i_q == c_idx_last) && (j_q == c_idx_last);
      done      = (state_q == DONE);
      res_data  = res_data_q;
      ld_err    = ld_err_q;
   end

endmodule : mac_matmul_engine
`default_nettype wire

// File: tb/tb_mac_matmul_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_matmul_engine
// Description : Self-checking bench. Two engines (N=2/OUT_W=16 and N=10/
//               OUT_W=32) share the stimulus bus; "act" selects which one is
//               driven and observed. Expected streams come from a plain
//               arithmetic matrix product in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_matmul_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ld_valid = 1'b0;
   logic        ld_sel = 1'b0;
   logic [3:0]  ld_row = '0;
   logic [3:0]  ld_col = '0;
   logic [15:0] ld_data = '0;
   logic        start = 1'b0;
   logic        res_ready = 1'b0;
   int          act = 0;

   always #5 clk = ~clk;

   logic        d2_err, d2_busy, d2_valid, d2_last, d2_done;
   logic [15:0] d2_data;
   logic        d10_err, d10_busy, d10_valid, d10_last, d10_done;
   logic [31:0] d10_data;
   logic        ldv2, ldv10, st2, st10;

   assign ldv2  = ld_valid && (act == 0);
   assign ldv10 = ld_valid && (act == 1);
   assign st2   = start && (act == 0);
   assign st10  = start && (act == 1);

   mac_matmul_engine #(.N(2), .DATA_W(16), .OUT_W(16)) u_dut2 (
      .clk(clk), .rst(rst), .ld_valid(ldv2), .ld_sel(ld_sel),
      .ld_row(ld_row[0:0]), .ld_col(ld_col[0:0]), .ld_data(ld_data),
      .ld_err(d2_err), .start(st2), .busy(d2_busy), .res_valid(d2_valid),
      .res_ready(res_ready), .res_data(d2_data), .res_last(d2_last),
      .done(d2_done));

   mac_matmul_engine #(.N(10), .DATA_W(16), .OUT_W(32)) u_dut10 (
      .clk(clk), .rst(rst), .ld_valid(ldv10), .ld_sel(ld_sel),
      .ld_row(ld_row), .ld_col(ld_col), .ld_data(ld_data),
      .ld_err(d10_err), .start(st10), .busy(d10_busy), .res_valid(d10_valid),
      .res_ready(res_ready), .res_data(d10_data), .res_last(d10_last),
      .done(d10_done));

   logic              o_valid, o_last, o_done, o_busy, o_err;
   logic signed [63:0] o_data;

   always_comb begin
      if (act == 0) begin
         o_valid = d2_valid; o_last = d2_last; o_done = d2_done;
         o_busy  = d2_busy;  o_err  = d2_err;
         o_data  = {{48{d2_data[15]}}, d2_data};
      end else begin
         o_valid = d10_valid; o_last = d10_last; o_done = d10_done;
         o_busy  = d10_busy;  o_err  = d10_err;
         o_data  = {{32{d10_data[31]}}, d10_data};
      end
   end

   // ------------------------------------------------------------------ model
   longint ma [0:1][0:15][0:15];
   longint mb [0:1][0:15][0:15];
   longint expq[$];
   longint got[$];
   int     errors = 0;
   int     checks = 0;
   int     last_cnt = 0;
   int     done_cnt = 0;

   function automatic int cur_n();
      return (act == 0) ? 2 : 10;
   endfunction

   function automatic int cur_w();
      return (act == 0) ? 16 : 32;
   endfunction

   function automatic longint narrow(longint v, int w);
`ifdef MAC_SAT_EN
      longint hi;
      hi = (longint'(1) <<< (w - 1)) - 1;
      if (v > hi) return hi;
      if (v < -hi - 1) return -hi - 1;
      return v;
`else
      return (v <<< (64 - w)) >>> (64 - w);
`endif
   endfunction

   task automatic check(input string name, input logic signed [63:0] a, input logic signed [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, a, e, $time);
      end
   endtask

   task automatic build_expected();
      int n;
      n = cur_n();
      expq.delete();
      got.delete();
      last_cnt = 0;
      done_cnt = 0;
      for (int i = 0; i < n; i++)
         for (int j = 0; j < n; j++) begin
            longint s;
            s = 0;
            for (int k = 0; k < n; k++) s += ma[act][i][k] * mb[act][k][j];
            expq.push_back(narrow(s, cur_w()));
         end
   endtask

   // ------------------------------------------------------- compare process
   initial begin
      bit                 hold_prev;
      bit                 done_exp;
      logic signed [63:0] hold_data;
      hold_prev = 0;
      done_exp  = 0;
      hold_data = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_prev = 0;
            done_exp  = 0;
         end else begin
            check("done", o_done, done_exp);
            if (o_done) done_cnt++;
            done_exp = 0;
            if (o_valid === 1'b1) begin
               if (expq.size() == 0) begin
                  check("valid_without_expected", o_valid, 0);
               end else begin
                  check("res_data", o_data, expq[0]);
                  check("res_last", o_last, expq.size() == 1);
               end
               if (hold_prev) check("res_data_stable", o_data, hold_data);
               if (res_ready && expq.size() != 0) begin
                  got.push_back(o_data);
                  if (o_last) last_cnt++;
                  if (expq.size() == 1) done_exp = 1;
                  void'(expq.pop_front());
               end
               hold_prev = !res_ready;
               hold_data = o_data;
            end else begin
               if (hold_prev) check("valid_held", o_valid, 1);
               hold_prev = 0;
            end
         end
      end
   end

   // --------------------------------------------------------- driver tasks
   // All driver tasks begin and end at 1 time unit after a rising edge.
   task automatic load(input bit sel, input int r, input int c, input longint v, input bit exp_err);
      ld_valid = 1'b1;
      ld_sel   = sel;
      ld_row   = 4'(r);
      ld_col   = 4'(c);
      ld_data  = 16'(v);
      if (!exp_err) begin
         if (sel) mb[act][r][c] = longint'($signed(16'(v)));
         else     ma[act][r][c] = longint'($signed(16'(v)));
      end
      @(posedge clk); #1;
      ld_valid = 1'b0;
      check("ld_err", o_err, exp_err);
   endtask

   task automatic kick();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound, input bit rnd, output int lat);
      bit found;
      found = 0;
      lat   = 1;
      for (int c = 0; c < bound; c++) begin
         if (rnd) res_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         lat++;
         if (o_done) begin
            found = 1;
            break;
         end
      end
      check("done_seen", found, 1);
      res_ready = 1'b1;
      @(posedge clk); #1;
      check("stream_complete", expq.size(), 0);
   endtask

   task automatic load_small();
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++) begin
            load(0, r, c, r*2 + c + 1, 0);
            load(1, r, c, r*2 + c + 5, 0);
         end
   endtask

   task automatic check_small_stream();
      longint e [4];
      e = '{19, 22, 43, 50};
      check("stream_len", got.size(), 4);
      for (int idx = 0; idx < 4; idx++)
         if (idx < got.size()) check("stream_val", got[idx], e[idx]);
   endtask

   // ------------------------------------------------------------- sequence
   initial begin
      int lat;
      for (int s = 0; s < 2; s++)
         for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
               ma[s][r][c] = 0;
               mb[s][r][c] = 0;
            end

      // Reset state of both engines
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy2", d2_busy, 0);
      check("rst_valid2", d2_valid, 0);
      check("rst_done2", d2_done, 0);
      check("rst_err2", d2_err, 0);
      check("rst_last2", d2_last, 0);
      check("rst_data2", d2_data, 0);
      check("rst_busy10", d10_busy, 0);
      check("rst_valid10", d10_valid, 0);
      check("rst_data10", d10_data, 0);
      rst = 1'b0;

      // N=2 known product, ready held high, latency
      act = 0;
      load_small();
      res_ready = 1'b1;
      build_expected();
      kick();
      wait_done(200, 0, lat);
      check("latency_n2", lat, 13);
      check_small_stream();
      check("last_count_n2", last_cnt, 1);
      check("done_count_n2", done_cnt, 1);

      // N=2 with random back-pressure
      build_expected();
      res_ready = 1'($urandom_range(0, 1));
      kick();
      wait_done(400, 1, lat);
      check_small_stream();

      // N=10 identity * B, ready held high
      act = 1;
      for (int r = 0; r < 10; r++)
         for (int c = 0; c < 10; c++) begin
            load(0, r, c, (r == c) ? 1 : 0, 0);
            load(1, r, c, r*10 + c - 50, 0);
         end
      res_ready = 1'b1;
      build_expected();
      kick();
      wait_done(2000, 0, lat);
      check("latency_n10", lat, 1101);
      check("stream_len_n10", got.size(), 100);
      for (int idx = 0; idx < 100; idx++)
         if (idx < got.size()) check("identity_val", got[idx], idx - 50);
      check("last_count_n10", last_cnt, 1);
      check("done_count_n10", done_cnt, 1);

      // Illegal writes: out-of-range index in IDLE
      load(0, 10, 0, 777, 1);
      load(1, 3, 11, 777, 1);
      @(posedge clk); #1;
      check("ld_err_pulse", o_err, 0);

      // Random full-range operands; write and start while busy are refused
      for (int r = 0; r < 10; r++)
         for (int c = 0; c < 10; c++) begin
            load(0, r, c, longint'($signed(16'($urandom))), 0);
            load(1, r, c, longint'($signed(16'($urandom))), 0);
         end
      build_expected();
      kick();
      @(posedge clk); #1;
      check("busy_in_mac", o_busy, 1);
      load(0, 0, 0, 1234, 1);
      @(posedge clk); #1;
      check("ld_err_pulse_busy", o_err, 0);
      kick();
      wait_done(3000, 0, lat);
      check("stream_len_busy", got.size(), 100);
      check("done_count_busy", done_cnt, 1);

      // Random operands with random back-pressure
      for (int r = 0; r < 10; r++)
         for (int c = 0; c < 10; c++) begin
            load(0, r, c, longint'($signed(16'($urandom))), 0);
            load(1, r, c, longint'($signed(16'($urandom))), 0);
         end
      build_expected();
      kick();
      wait_done(6000, 1, lat);
      check("stream_len_rand", got.size(), 100);

      // Narrowing boundary: N=2, every element -32768, sum 2^31 into 16 bits
      act = 0;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++) begin
            load(0, r, c, -32768, 0);
            load(1, r, c, -32768, 0);
         end
      build_expected();
      kick();
      wait_done(200, 0, lat);
      check("stream_len_sat", got.size(), 4);
      for (int idx = 0; idx < 4; idx++)
         if (idx < got.size()) begin
`ifdef MAC_SAT_EN
            check("sat_val", got[idx], 32767);
`else
            check("wrap_val", got[idx], 0);
`endif
         end

      // Reset in the middle of C[0][1], then a fresh full run
      load_small();
      build_expected();
      kick();
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("accepted_before_rst", got.size(), 1);
      rst = 1'b1;
      expq.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_mid_busy", o_busy, 0);
      check("rst_mid_valid", o_valid, 0);
      check("rst_mid_done", o_done, 0);
      build_expected();
      kick();
      wait_done(200, 0, lat);
      check("latency_after_rst", lat, 13);
      check_small_stream();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

endmodule : tb_mac_matmul_engine
`default_nettype wire

// File: doc/mac_matmul_engine.md
Name: mac_matmul_engine

Overview:
- Parametrised successor to the fixed 10x10 MAC controller.
- Holds two NxN signed operand matrices A and B in internal register arrays, loaded through a write port.
- On start, computes C = A*B with a single sequential multiply-accumulate datapath.
- Streams C in row-major order over a valid/ready interface, replacing the 100 flat result ports.

Parameters:
- N, 10, matrix dimension (2..16)
- DATA_W, 16, signed operand width
- OUT_W, 32, signed result width on res_data
- ACC_W, 2*DATA_W+$clog2(N), internal accumulator width (derived localparam, not overridable)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- ld_valid  in  1  write strobe for operand memory
- ld_sel  in  1  0 = write A, 1 = write B
- ld_row  in  $clog2(N)  row index
- ld_col  in  $clog2(N)  column index
- ld_data  in  DATA_W  signed element value
- ld_err  out  1  one-cycle pulse: write rejected (busy or index >= N)
- start  in  1  begin multiplication; sampled only in IDLE
- busy  out  1  high in MAC, EMIT and DONE states
- res_valid  out  1  result element available
- res_ready  in  1  consumer accepts element
- res_data  out  OUT_W  signed C[i][j]
- res_last  out  1  high with C[N-1][N-1]
- done  out  1  one-cycle pulse after the final result is accepted

Behaviour:
- Reset (synchronous, active-high): state=IDLE; i,j,k=0; acc=0; busy, res_valid, res_last, done, ld_err=0; res_data=0. A/B contents are retained, not cleared.
- Load: in IDLE, ld_valid with in-range indices writes in the same edge. ld_valid while busy, or with an index >= N, performs no write and pulses ld_err the next cycle.
- Start and load in the same cycle: the write commits first, so the computation sees the new value.
- IDLE -> MAC when start=1. start in any other state is ignored.
- MAC:
  - One k per cycle: acc <= (k==0 ? 0 : acc) + A[i][k]*B[k][j].
  - Full-precision signed product, sign-extended to ACC_W.
  - After k=N-1, go to EMIT, with res_data loaded from the final acc.
- EMIT:
  - res_valid=1 and res_data held stable until res_valid&res_ready.
  - res_last = (i==N-1 && j==N-1).
  - On handshake: j++; on j wrap, j=0 and i++. Return to MAC with k=0 and res_valid dropped in the same edge.
  - After the handshake on the last element, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: each element takes N MAC cycles plus at least 1 EMIT cycle. With res_ready tied high, start -> done = N*N*(N+1)+1 cycles.
- res_ready asserted while res_valid=0 is ignored. No combinational path from res_ready to res_valid.
- Width reduction ACC_W -> OUT_W: sign-extend if ACC_W <= OUT_W. Otherwise truncate to the low OUT_W bits (wrap), unless the optional feature below is enabled.
- Reset mid-operation: the computation is aborted immediately; no done pulse; the partial stream is discarded.

Optional Feature:
- Macro: MAC_SAT_EN.
- Defined: when ACC_W > OUT_W, res_data is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Undefined: wrap (truncate to low OUT_W bits). Identical when ACC_W <= OUT_W.

Decomposition:
- Shared package mac_pkg:
  - FSM state enum (IDLE, MAC, EMIT, DONE)
  - ld_sel encodings (SEL_A=0, SEL_B=1)
  - saturate/wrap narrowing function
- Natural sub-module mac_unit: registered signed multiply-accumulate with clear, parametrised on DATA_W and ACC_W.
- Address counters, operand memories and FSM stay in the top level.

Test Plan:
- N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], res_ready=1 -> stream 19,22,43,50; res_last on 50; done 13 cycles after start.
- N=10, A=identity, B[r][c]=r*10+c-50 -> 100 results equal B row-major; exactly one res_last; exactly one done.
- N=2, res_ready toggled pseudo-randomly -> same 19,22,43,50; res_data stable while valid&&!ready; no drops or duplicates.
- Illegal writes: ld_valid during MAC, and ld_row=N in IDLE -> ld_err pulses; memory unchanged; second start during busy ignored (one stream only).
- DATA_W=16, OUT_W=16, N=2, all elements -32768 -> with MAC_SAT_EN every result 32767; without it every result 0 (2^31 wrapped).
- rst asserted mid-MAC on element C[0][1] -> next cycle busy=0, res_valid=0; fresh start reproduces the full correct stream.
